// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer.
//   fsm_t      : internal game states; ST_WAIT is reported externally as ST_RUN
//   DIR_*      : direction codes carried on dir
//   rev_dir    : opposite direction (up<->down, left<->right)
//   bcd_inc    : two-digit BCD increment (callers handle saturation)
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_OVER  = 3'd3,
    ST_WAIT  = 3'd4
  } fsm_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step-period timer for the snake sequencer.
//   clk, rst_n : clock, async active-low reset
//   run        : count this cycle (held otherwise)
//   restart    : zero the counter and load the period from speed
//   speed      : speed level 0..3, period = TICK_BASE >> speed
//   wrap       : high in the cycle the counter sits at period-1 while running
module snake_tick_gen #(
  parameter logic [23:0] TICK_BASE = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] speed,
  output logic       wrap
);

  logic [23:0] cnt;
  logic [23:0] period;

  assign wrap = run && (cnt == period - 24'd1);

  // The period is only reloaded at a wrap (or restart), so a speed change
  // never truncates or stretches the period already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= TICK_BASE;
    end else if (restart || wrap) begin
      cnt    <= '0;
      period <= TICK_BASE >> speed;
    end else if (run) begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button events, step scheduling, direction
// arbitration, game state and BCD score.
//   clk, rst_n       : clock, async active-low reset
//   start, esc       : debounced button levels (rising edge = event)
//   up/down/left/right : direction button levels
//   mode             : [1:0] speed level, [5:2] ignored
//   step_done/hit/eat: datapath completion pulse and its flags
//   step, clear      : one-cycle requests to the datapath
//   dir              : committed direction
//   state            : 0 idle, 1 run, 2 pause, 3 over
//   score            : {tens, ones} BCD
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [23:0] TICK_BASE = 24'd5_000_000,
  parameter logic [7:0]  SCORE_MAX = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       esc,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [5:0] mode,
  input  logic       step_done,
  input  logic       hit,
  input  logic       eat,
  output logic       step,
  output logic       clear,
  output logic [1:0] dir,
  output logic [1:0] state,
  output logic [7:0] score
);

  fsm_t       st;
  logic [5:0] btn, btn_q, ev;
  logic       ev_start, ev_esc;
  logic       dir_ev;
  logic [1:0] dir_sel;
  logic [1:0] pending;
  logic       esc_lat;
  logic       wrap, run, restart;
  logic       unused_mode;

  assign unused_mode = ^mode[5:2];

  // Edge registers start at 1 so a button held through reset must be
  // released before it can fire.
  assign btn = {start, esc, up, down, left, right};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '1;
      ev    <= '0;
    end else begin
      btn_q <= btn;
      ev    <= btn & ~btn_q;
    end
  end
  assign ev_start = ev[5];
  assign ev_esc   = ev[4];

  always_comb begin
    dir_ev  = 1'b1;
    dir_sel = DIR_UP;
    if      (ev[3]) dir_sel = DIR_UP;
    else if (ev[2]) dir_sel = DIR_DOWN;
    else if (ev[1]) dir_sel = DIR_LEFT;
    else if (ev[0]) dir_sel = DIR_RIGHT;
    else            dir_ev  = 1'b0;
  end

  assign run     = (st == ST_RUN);
  assign restart = ev_start && (st == ST_IDLE || st == ST_OVER);

  snake_tick_gen #(.TICK_BASE(TICK_BASE)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .restart (restart),
    .speed   (mode[1:0]),
    .wrap    (wrap)
  );

  assign state = (st == ST_WAIT) ? 2'd1 : st[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      step    <= 1'b0;
      clear   <= 1'b0;
      dir     <= DIR_RIGHT;
      pending <= DIR_RIGHT;
      score   <= 8'h00;
      esc_lat <= 1'b0;
    end else begin
      step  <= 1'b0;
      clear <= 1'b0;
      // Reverse check is against the committed direction, not pending.
      if (dir_ev && (st == ST_RUN || st == ST_WAIT || st == ST_PAUSE) &&
          dir_sel != rev_dir(dir))
        pending <= dir_sel;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (ev_start) begin
            clear   <= 1'b1;
            score   <= 8'h00;
            dir     <= DIR_RIGHT;
            pending <= DIR_RIGHT;
            st      <= ST_RUN;
          end else if (ev_esc && st == ST_OVER) begin
            st <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // A step due in the same cycle as esc still goes out; the pause
          // then takes effect once the step completes.
          if (wrap) begin
            step    <= 1'b1;
            dir     <= pending;
            esc_lat <= ev_esc;
            st      <= ST_WAIT;
          end else if (ev_esc) begin
            st <= ST_PAUSE;
          end
        end
        ST_WAIT: begin
          if (ev_esc) esc_lat <= 1'b1;
          if (step_done) begin
            esc_lat <= 1'b0;
            if (hit) begin
              st <= ST_OVER;
            end else begin
              if (eat) score <= (score == SCORE_MAX) ? score : bcd_inc(score);
              st <= (esc_lat || ev_esc) ? ST_PAUSE : ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (ev_start)    st <= ST_IDLE;
          else if (ev_esc) st <= ST_RUN;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

  localparam int BASE = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3, M_WAIT = 4;
  localparam int B_START = 0, B_ESC = 1, B_UP = 2, B_DOWN = 3, B_LEFT = 4, B_RIGHT = 5;

  logic clk = 1'b0;
  logic rst_n, start, esc, up, down, left, right, step_done, hit, eat;
  logic [5:0] mode;
  logic step, clear;
  logic [1:0] dir, state;
  logic [7:0] score;

  int tests = 0;
  int fails = 0;

  // behavioural model (game-level view)
  int m_st, m_score, m_dir, m_pend, m_p, m_elapsed;
  bit m_esc;
  int opp [4] = '{1, 0, 3, 2};

  snake_game_ctrl #(.TICK_BASE(24'd16), .SCORE_MAX(8'h99)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .esc(esc), .up(up), .down(down),
    .left(left), .right(right), .mode(mode), .step_done(step_done), .hit(hit),
    .eat(eat), .step(step), .clear(clear), .dir(dir), .state(state), .score(score)
  );

  always #5 clk = ~clk;

  function automatic int rep(input int s);
    return (s == M_WAIT) ? M_RUN : s;
  endfunction

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; counter time advances only for edges spent in RUN.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (m_st == M_RUN) m_elapsed++;
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_score = 0; m_dir = 3; m_pend = 3; m_p = BASE; m_elapsed = 0; m_esc = 0;
  endtask

  task automatic model_event(input int b);
    if (b == B_START) begin
      if (m_st == M_IDLE || m_st == M_OVER) begin
        m_st = M_RUN; m_score = 0; m_dir = 3; m_pend = 3; m_elapsed = 0;
        m_p = BASE >> mode[1:0];
      end else if (m_st == M_PAUSE) m_st = M_IDLE;
    end else if (b == B_ESC) begin
      case (m_st)
        M_RUN:   m_st = M_PAUSE;
        M_PAUSE: m_st = M_RUN;
        M_OVER:  m_st = M_IDLE;
        M_WAIT:  m_esc = 1;
        default: ;
      endcase
    end else if (m_st == M_RUN || m_st == M_WAIT || m_st == M_PAUSE) begin
      if ((b - 2) != opp[m_dir]) m_pend = b - 2;
    end
  endtask

  task automatic press(input int b);
    case (b)
      B_START: start = 1'b1;
      B_ESC:   esc = 1'b1;
      B_UP:    up = 1'b1;
      B_DOWN:  down = 1'b1;
      B_LEFT:  left = 1'b1;
      default: right = 1'b1;
    endcase
    cyc(1);
    start = 0; esc = 0; up = 0; down = 0; left = 0; right = 0;
    cyc(1);
    model_event(b);
  endtask

  task automatic wait_step_chk();
    int n, exp_gap;
    exp_gap = m_p - m_elapsed;
    n = 0;
    while (step !== 1'b1 && n < 200) begin cyc(1); n++; end
    chk("step_seen", step, 1);
    chk("step_gap", n, exp_gap);
    chk("step_dir", dir, m_pend);
    chk("step_no_clear", clear, 0);
    m_dir = m_pend;
    m_p = BASE >> mode[1:0];
    m_st = M_WAIT;
    m_elapsed = 0;
  endtask

  task automatic done_pulse(input logic h, input logic e);
    step_done = 1'b1; hit = h; eat = e;
    cyc(1);
    step_done = 1'b0; hit = 1'b0; eat = 1'b0;
    if (m_st == M_WAIT) begin
      if (h) m_st = M_OVER;
      else begin
        if (e && m_score < 99) m_score++;
        m_st = m_esc ? M_PAUSE : M_RUN;
      end
      m_esc = 0;
      m_elapsed = 0;
    end
  endtask

  task automatic run_step(input logic h, input logic e);
    wait_step_chk();
    cyc(1);
    chk("step_one_cycle", step, 0);
    cyc(1);
    done_pulse(h, e);
    chk("state_after_done", state, rep(m_st));
    chk("score_after_done", score, to_bcd(m_score));
  endtask

  initial begin
    bit seen;
    int k;
    rst_n = 0; start = 1; esc = 0; up = 0; down = 0; left = 0; right = 0;
    step_done = 0; hit = 0; eat = 0; mode = 6'b1010_00;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_step", step, 0);
    chk("rst_clear", clear, 0);
    chk("rst_dir", dir, 2'b11);
    chk("rst_state", state, 0);
    chk("rst_score", score, 8'h00);

    // start held through reset must not fire
    rst_n = 1;
    seen = 0;
    repeat (6) begin cyc(1); if (clear || state != 0) seen = 1; end
    chk("held_start_ignored", seen, 0);
    start = 0;
    cyc(2);
    press(B_START);
    chk("start_clear", clear, 1);
    chk("start_state", state, 1);
    cyc(1);
    chk("clear_one_cycle", clear, 0);
    run_step(0, 0);
    chk("first_dir", dir, 2'b11);

    // reverse discard then accepted down
    press(B_LEFT);
    press(B_DOWN);
    run_step(0, 0);
    chk("dir_down", dir, 2'b01);
    press(B_UP);
    run_step(0, 0);
    chk("dir_keep_down", dir, 2'b01);

    // step_done outside WAIT ignored
    done_pulse(1, 1);
    chk("stray_done_state", state, 1);
    chk("stray_done_score", score, to_bcd(m_score));

    // speed change: new period only after the next wrap
    mode = 6'b0101_10;
    run_step(0, 0);
    run_step(0, 0);
    cyc(1);
    mode = 6'b0000_00;
    run_step(0, 0);
    run_step(0, 0);

    // randomized play
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 2);
      repeat (k) press(2 + int'($urandom_range(0, 3)));
      run_step(0, logic'($urandom_range(0, 1)));
    end

    // collision beats eat, then restart and esc from OVER
    run_step(1, 1);
    chk("over_state", state, 3);
    press(B_START);
    chk("restart_clear", clear, 1);
    chk("restart_score", score, 8'h00);
    chk("restart_state", state, 1);
    run_step(1, 0);
    press(B_ESC);
    chk("over_esc_idle", state, 0);

    // score counting and saturation
    press(B_START);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) press(2 + int'($urandom_range(0, 3)));
      run_step(0, 1);
    end
    chk("score_12", score, 8'h12);
    while (m_score < 99) run_step(0, 1);
    chk("score_99", score, 8'h99);
    run_step(0, 1);
    chk("score_sat", score, 8'h99);

    // esc during WAIT
    wait_step_chk();
    press(B_ESC);
    chk("wait_reports_run", state, 1);
    done_pulse(0, 0);
    chk("paused_after_done", state, 2);
    seen = 0;
    repeat (30) begin cyc(1); if (step) seen = 1; end
    chk("no_step_paused", seen, 0);
    press(B_ESC);
    chk("resume_state", state, 1);
    run_step(0, 0);
    press(B_ESC);
    chk("run_pause", state, 2);
    press(B_ESC);
    run_step(0, 0);
    press(B_ESC);
    press(B_START);
    chk("pause_start_idle", state, 0);

    // reset mid-WAIT
    press(B_START);
    press(B_DOWN);
    run_step(0, 1);
    wait_step_chk();
    cyc(1);
    rst_n = 0;
    #1;
    chk("arst_step", step, 0);
    chk("arst_clear", clear, 0);
    chk("arst_dir", dir, 2'b11);
    chk("arst_state", state, 0);
    chk("arst_score", score, 8'h00);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (step || clear) seen = 1; end
    chk("rst_no_pulses", seen, 0);
    model_reset();
    rst_n = 1;
    cyc(2);
    chk("post_rst_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
